// File: rtl/fft_peak_detect_pkg.sv
// Shared definitions for the FFT peak detector.
// Holds default sizes, the peak-search FSM state type and small sizing
// helpers used by fft_peak_detect and cplx_pow.
// Optional feature macro used by the top: PEAK_THRESH_EN.
package fft_peak_detect_pkg;

    // Default sample width and log2 of the FFT length
    localparam int WIDTH_DEF = 16;
    localparam int NALL_DEF  = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } peakState_e;

    // Number of bins per frame, N = 2^nall
    function automatic int frameLen(input int nall);
        return 1 << nall;
    endfunction

    // Width of a power sample, PW = 2*width
    function automatic int powWidth(input int w);
        return 2 * w;
    endfunction

    // Highest bin that takes part in the peak search, N/2-1
    function automatic int searchHi(input int nall);
        return (1 << nall) / 2 - 1;
    endfunction

endpackage

// File: rtl/fft_peak_detect_cplx_pow.sv
// cplx_pow: two-stage registered complex power, re*re + im*im.
// Ports:
//   clk, areset         - clock, asynchronous active-high reset
//   en_i, cnt_i         - input sample valid and bin index
//   re_i, im_i          - signed real/imaginary parts
//   en_o, cnt_o, pow_o  - valid, bin index and unsigned power, 2 clocks later
// Data registers only load on valid samples, so they hold across bubbles.
module cplx_pow
    import fft_peak_detect_pkg::*;
#(
    parameter int width = WIDTH_DEF,
    parameter int NALL  = NALL_DEF
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    en_i,
    input  logic [NALL-1:0]         cnt_i,
    input  logic signed [width-1:0] re_i,
    input  logic signed [width-1:0] im_i,
    output logic                    en_o,
    output logic [NALL-1:0]         cnt_o,
    output logic [2*width-1:0]      pow_o
);

    localparam int PW = powWidth(width);

    logic signed [PW-1:0] reExt;
    logic signed [PW-1:0] imExt;
    logic signed [PW-1:0] reSq_d;
    logic signed [PW-1:0] imSq_d;
    logic signed [PW-1:0] reSq_q;
    logic signed [PW-1:0] imSq_q;
    logic [PW-1:0]        pow_d;
    logic [PW-1:0]        pow_q;
    logic                 en1_q;
    logic                 en2_q;
    logic [NALL-1:0]      cnt1_q;
    logic [NALL-1:0]      cnt2_q;

    // Squares are formed at full PW width; each is non-negative and at most
    // 2^(2*width-2), so the unsigned sum never exceeds 2^(2*width-1).
    always_comb begin
        reExt  = {{width{re_i[width-1]}}, re_i};
        imExt  = {{width{im_i[width-1]}}, im_i};
        reSq_d = reExt * reExt;
        imSq_d = imExt * imExt;
        pow_d  = $unsigned(reSq_q) + $unsigned(imSq_q);
    end

    // Stage 1 registers the squares, stage 2 the sum; valid and index ride along.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            en1_q  <= 1'b0;
            en2_q  <= 1'b0;
            cnt1_q <= '0;
            cnt2_q <= '0;
            reSq_q <= '0;
            imSq_q <= '0;
            pow_q  <= '0;
        end else begin
            en1_q <= en_i;
            en2_q <= en1_q;
            if (en_i) begin
                reSq_q <= reSq_d;
                imSq_q <= imSq_d;
                cnt1_q <= cnt_i;
            end
            if (en1_q) begin
                pow_q  <= pow_d;
                cnt2_q <= cnt1_q;
            end
        end
    end

    assign en_o  = en2_q;
    assign cnt_o = cnt2_q;
    assign pow_o = pow_q;

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin power stream plus per-frame peak report.
// Ports:
//   clk, areset                     - clock, asynchronous active-high reset
//   din_en, din_cnt, din_re, din_im - natural-order FFT bin stream
//   pow_en, pow_cnt, pow_out        - power stream, 2 clocks behind din
//   peak_valid                      - one-cycle pulse per finished/abandoned frame
//   peak_bin, peak_pow              - strongest bin in LO_BIN..N/2-1 and its power
//   peak_hit                        - peak qualified against THRESH
//   frame_err                       - frame had a bin index discontinuity
// Optional macro PEAK_THRESH_EN: when defined peak_hit = (peak_pow >= THRESH),
// otherwise peak_hit is simply 1 on every report.
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int width  = WIDTH_DEF,
    parameter int NALL   = NALL_DEF,
    parameter int LO_BIN = 1,
    parameter int THRESH = 0
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    din_en,
    input  logic [NALL-1:0]         din_cnt,
    input  logic signed [width-1:0] din_re,
    input  logic signed [width-1:0] din_im,
    output logic                    pow_en,
    output logic [NALL-1:0]         pow_cnt,
    output logic [2*width-1:0]      pow_out,
    output logic                    peak_valid,
    output logic [NALL-1:0]         peak_bin,
    output logic [2*width-1:0]      peak_pow,
    output logic                    peak_hit,
    output logic                    frame_err
);

    localparam int              N    = frameLen(NALL);
    localparam int              PW   = powWidth(width);
    localparam logic [NALL-1:0] LO   = NALL'(LO_BIN);
    localparam logic [NALL-1:0] HI   = NALL'(searchHi(NALL));
    localparam logic [NALL-1:0] LAST = NALL'(N - 1);
    localparam logic [NALL-1:0] ONE  = NALL'(1);
`ifdef PEAK_THRESH_EN
    localparam logic [PW-1:0]   THR  = PW'(THRESH);
`endif

    peakState_e      state_q, state_d;
    logic [PW-1:0]   maxPow_q, maxPow_d;
    logic [NALL-1:0] maxBin_q, maxBin_d;
    logic [NALL-1:0] prevCnt_q, prevCnt_d;
    logic            err_q, err_d;
    logic            peakValid_q, peakValid_d;
    logic [NALL-1:0] peakBin_q, peakBin_d;
    logic [PW-1:0]   peakPow_q, peakPow_d;
    logic            peakHit_q, peakHit_d;
    logic            frameErr_q, frameErr_d;

    logic            startFrame;
    logic            inRange;
    logic            doInit;
    logic            doReport;
    logic [PW-1:0]   basePow, accPow, reportPow;
    logic [NALL-1:0] baseBin, accBin, reportBin;
    logic            reportErr;

    cplx_pow #(
        .width (width),
        .NALL  (NALL)
    ) uPow (
        .clk    (clk),
        .areset (areset),
        .en_i   (din_en),
        .cnt_i  (din_cnt),
        .re_i   (din_re),
        .im_i   (din_im),
        .en_o   (pow_en),
        .cnt_o  (pow_cnt),
        .pow_o  (pow_out)
    );

    // Frame tracking, running max and report generation.
    // A bin 0 sample starts a frame from IDLE or DONE (giving zero-gap
    // back-to-back frames) and abandons a frame still in RUN. The running max
    // restarts at (0, LO) so an all-zero frame reports LO_BIN; strict
    // greater-than keeps the lowest bin on ties.
    always_comb begin
        state_d     = state_q;
        maxPow_d    = maxPow_q;
        maxBin_d    = maxBin_q;
        prevCnt_d   = prevCnt_q;
        err_d       = err_q;
        peakValid_d = 1'b0;
        peakBin_d   = peakBin_q;
        peakPow_d   = peakPow_q;
        peakHit_d   = peakHit_q;
        frameErr_d  = frameErr_q;
        doInit      = 1'b0;
        doReport    = 1'b0;
        reportPow   = maxPow_q;
        reportBin   = maxBin_q;
        reportErr   = err_q;

        startFrame = pow_en && (pow_cnt == '0);
        inRange    = (pow_cnt >= LO) && (pow_cnt <= HI);
        basePow    = startFrame ? '0 : maxPow_q;
        baseBin    = startFrame ? LO : maxBin_q;
        if (inRange && (pow_out > basePow)) begin
            accPow = pow_out;
            accBin = pow_cnt;
        end else begin
            accPow = basePow;
            accBin = baseBin;
        end

        if (pow_en) begin
            case (state_q)
                IDLE: begin
                    if (startFrame) begin
                        doInit  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (startFrame) begin
                        doReport  = 1'b1;
                        reportErr = 1'b1;
                        doInit    = 1'b1;
                    end else begin
                        err_d     = err_q | (pow_cnt != prevCnt_q + ONE);
                        maxPow_d  = accPow;
                        maxBin_d  = accBin;
                        prevCnt_d = pow_cnt;
                        if (pow_cnt == LAST) begin
                            state_d   = DONE;
                            doReport  = 1'b1;
                            reportPow = accPow;
                            reportBin = accBin;
                            reportErr = err_d;
                        end
                    end
                end
                DONE: begin
                    if (startFrame) begin
                        doInit  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end

        if (doInit) begin
            err_d     = 1'b0;
            maxPow_d  = accPow;
            maxBin_d  = accBin;
            prevCnt_d = pow_cnt;
        end

        if (doReport) begin
            peakValid_d = 1'b1;
            peakBin_d   = reportBin;
            peakPow_d   = reportPow;
            frameErr_d  = reportErr;
`ifdef PEAK_THRESH_EN
            peakHit_d   = (reportPow >= THR);
`else
            peakHit_d   = 1'b1;
`endif
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            maxPow_q    <= '0;
            maxBin_q    <= '0;
            prevCnt_q   <= '0;
            err_q       <= 1'b0;
            peakValid_q <= 1'b0;
            peakBin_q   <= '0;
            peakPow_q   <= '0;
            peakHit_q   <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            maxPow_q    <= maxPow_d;
            maxBin_q    <= maxBin_d;
            prevCnt_q   <= prevCnt_d;
            err_q       <= err_d;
            peakValid_q <= peakValid_d;
            peakBin_q   <= peakBin_d;
            peakPow_q   <= peakPow_d;
            peakHit_q   <= peakHit_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign peak_valid = peakValid_q;
    assign peak_bin   = peakBin_q;
    assign peak_pow   = peakPow_q;
    assign peak_hit   = peakHit_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect with N = 16 bins.
// The power stream is modelled as "input two clocks ago, squared"; the peak
// report is modelled per frame from the bin arrays the bench sends.
module tb_fft_peak_detect;

    localparam int W  = 16;
    localparam int NA = 4;
    localparam int NB = 16;
    localparam int LO = 1;
    localparam int TH = 1000;
`ifdef PEAK_THRESH_EN
    localparam logic TIE_HIT = 1'b0;
`else
    localparam logic TIE_HIT = 1'b1;
`endif

    logic                clk = 1'b0;
    logic                areset = 1'b1;
    logic                din_en;
    logic [NA-1:0]       din_cnt;
    logic signed [W-1:0] din_re;
    logic signed [W-1:0] din_im;
    logic                pow_en;
    logic [NA-1:0]       pow_cnt;
    logic [2*W-1:0]      pow_out;
    logic                peak_valid;
    logic [NA-1:0]       peak_bin;
    logic [2*W-1:0]      peak_pow;
    logic                peak_hit;
    logic                frame_err;

    fft_peak_detect #(
        .width  (W),
        .NALL   (NA),
        .LO_BIN (LO),
        .THRESH (TH)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .din_en     (din_en),
        .din_cnt    (din_cnt),
        .din_re     (din_re),
        .din_im     (din_im),
        .pow_en     (pow_en),
        .pow_cnt    (pow_cnt),
        .pow_out    (pow_out),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_pow   (peak_pow),
        .peak_hit   (peak_hit),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     bin;
        longint pow;
        logic   hit;
        logic   err;
    } peakRec_t;

    int       nChecks = 0;
    int       nFails  = 0;
    int       cycle   = 0;
    logic     started = 1'b0;
    logic     h0En, h1En;
    int       h0Cnt, h1Cnt;
    longint   h0Pow, h1Pow;
    peakRec_t expQ[$];
    peakRec_t hold;
    int       pulseCycles[$];
    longint   capQ[$];
    int       capBin = -1;
    int       frameRe[NB];
    int       frameIm[NB];

    function automatic longint sq(input int re, input int im);
        return longint'(re) * re + longint'(im) * im;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Record what was presented to the DUT at each rising edge.
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            h0En = 1'b0; h0Cnt = 0; h0Pow = 0;
            h1En = 1'b0; h1Cnt = 0; h1Pow = 0;
        end else begin
            cycle++;
            h1En  = h0En;  h1Cnt = h0Cnt;  h1Pow = h0Pow;
            h0En  = din_en;
            h0Cnt = int'(din_cnt);
            h0Pow = sq(int'(din_re), int'(din_im));
        end
    end

    // Compare process: power stream every cycle, peak report on pulses, held values otherwise.
    always @(negedge clk) begin
        if (areset) begin
            hold = '{0, 0, 1'b0, 1'b0};
        end else if (started) begin
            checkOutput("pow_en", pow_en, h1En);
            if (h1En) begin
                checkOutput("pow_cnt", pow_cnt, h1Cnt);
                checkOutput("pow_out", pow_out, h1Pow);
                if (h1Cnt == capBin) capQ.push_back(longint'(pow_out));
            end
            if (peak_valid) begin
                pulseCycles.push_back(cycle);
                checkOutput("pulse_expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) hold = expQ.pop_front();
            end
            checkOutput("peak_bin", peak_bin, hold.bin);
            checkOutput("peak_pow", peak_pow, hold.pow);
            checkOutput("peak_hit", peak_hit, hold.hit);
            checkOutput("frame_err", frame_err, hold.err);
        end
    end

    task automatic applyStimulus(input logic en, input int cnt, input int re, input int im);
        @(posedge clk);
        #1;
        din_en  = en;
        din_cnt = cnt[NA-1:0];
        din_re  = re[W-1:0];
        din_im  = im[W-1:0];
    endtask

    task automatic clearFrame();
        for (int i = 0; i < NB; i++) begin
            frameRe[i] = 0;
            frameIm[i] = 0;
        end
    endtask

    // Queue the expected report for the frame, then stream it.
    task automatic sendFrame(input int skipBin, input int gapMax);
        peakRec_t r;
        r.bin = LO;
        r.pow = 0;
        for (int i = LO; i <= NB / 2 - 1; i++) begin
            if (i != skipBin && sq(frameRe[i], frameIm[i]) > r.pow) begin
                r.pow = sq(frameRe[i], frameIm[i]);
                r.bin = i;
            end
        end
`ifdef PEAK_THRESH_EN
        r.hit = (r.pow >= TH);
`else
        r.hit = 1'b1;
`endif
        r.err = (skipBin >= 0);
        expQ.push_back(r);
        for (int i = 0; i < NB; i++) begin
            if (i != skipBin) begin
                applyStimulus(1'b1, i, frameRe[i], frameIm[i]);
                if (gapMax > 0) repeat ($urandom_range(1, gapMax)) applyStimulus(1'b0, i, 0, 0);
            end
        end
    endtask

    task automatic waitDrain();
        int k = 0;
        applyStimulus(1'b0, 0, 0, 0);
        while (expQ.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        checkOutput("drain_pending", expQ.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int nCap;
        din_en = 1'b0; din_cnt = '0; din_re = '0; din_im = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pow_en", pow_en, 0);
        checkOutput("rst_pow_out", pow_out, 0);
        checkOutput("rst_peak_valid", peak_valid, 0);
        checkOutput("rst_peak_bin", peak_bin, 0);
        checkOutput("rst_peak_pow", peak_pow, 0);
        checkOutput("rst_peak_hit", peak_hit, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        areset = 1'b0;
        started = 1'b1;

        $display("[TB] single tone at bin 5");
        clearFrame();
        frameRe[5] = 300; frameIm[5] = -400;
        capBin = 5;
        nCap = capQ.size();
        sendFrame(-1, 0);
        waitDrain();
        checkOutput("f1_pow5_seen", capQ.size(), nCap + 1);
        if (capQ.size() > nCap) checkOutput("f1_pow5", capQ[nCap], 250000);
        checkOutput("f1_pulses", pulseCycles.size(), 1);
        checkOutput("f1_bin", peak_bin, 5);
        checkOutput("f1_pow", peak_pow, 250000);
        checkOutput("f1_err", frame_err, 0);
        checkOutput("f1_hit", peak_hit, 1);

        $display("[TB] DC and upper half excluded");
        clearFrame();
        frameRe[0] = 1000; frameRe[3] = 10;
        for (int i = 8; i < NB; i++) frameRe[i] = 2000;
        sendFrame(-1, 0);
        waitDrain();
        checkOutput("dc_bin", peak_bin, 3);
        checkOutput("dc_pow", peak_pow, 100);

        $display("[TB] tie resolves to lowest bin");
        clearFrame();
        frameRe[2] = 7; frameIm[2] = 7; frameRe[6] = 7; frameIm[6] = 7;
        sendFrame(-1, 0);
        waitDrain();
        checkOutput("tie_bin", peak_bin, 2);
        checkOutput("tie_pow", peak_pow, 98);
        checkOutput("tie_hit", peak_hit, TIE_HIT);

        $display("[TB] index skip 4 -> 6");
        clearFrame();
        frameRe[3] = 30; frameIm[3] = 40;
        sendFrame(5, 0);
        waitDrain();
        checkOutput("skip_err", frame_err, 1);
        checkOutput("skip_bin", peak_bin, 3);

        $display("[TB] random gaps, no skip");
        sendFrame(-1, 5);
        waitDrain();
        checkOutput("gap_err", frame_err, 0);
        checkOutput("gap_pow", peak_pow, 2500);

        $display("[TB] back-to-back frames with extreme samples");
        clearFrame();
        frameRe[4] = -32768; frameIm[4] = -32768;
        capBin = 4;
        nCap = capQ.size();
        sendFrame(-1, 0);
        clearFrame();
        frameRe[2] = 7; frameIm[2] = 7; frameRe[6] = 7; frameIm[6] = 7;
        sendFrame(-1, 0);
        waitDrain();
        capBin = -1;
        checkOutput("ext_pow_seen", capQ.size() > nCap, 1);
        if (capQ.size() > nCap) checkOutput("ext_pow", capQ[nCap], 64'h8000_0000);
        n = pulseCycles.size();
        checkOutput("b2b_pulses", n, 7);
        if (n >= 2) checkOutput("b2b_spacing", pulseCycles[n-1] - pulseCycles[n-2], 16);
        checkOutput("b2b_bin", peak_bin, 2);

        $display("[TB] reset mid-frame");
        clearFrame();
        frameRe[3] = 30; frameIm[3] = 40;
        n = pulseCycles.size();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i, frameRe[i], frameIm[i]);
        @(posedge clk);
        #1;
        areset = 1'b1;
        din_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mid_bin", peak_bin, 0);
        areset = 1'b0;
        repeat (20) applyStimulus(1'b0, 0, 0, 0);
        checkOutput("rst_mid_no_pulse", pulseCycles.size(), n);
        clearFrame();
        frameRe[5] = 300; frameIm[5] = -400;
        sendFrame(-1, 0);
        waitDrain();
        checkOutput("rst_next_pulses", pulseCycles.size(), n + 1);
        checkOutput("rst_next_bin", peak_bin, 5);
        checkOutput("rst_next_pow", peak_pow, 250000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
